// File: rtl/present80_enc_core.sv
// rtl/present80_enc_core.sv - iterative PRESENT-80 encryption core, one round per clock
module present80_enc_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key_in,
    input  logic [63:0] din,
    output logic        busy,
    output logic        done,
    output logic [63:0] dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_t;

    localparam logic [4:0] LAST_RND = 5'd31;

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [63:0] dout_q, dout_d;
    logic        done_q, done_d;

    logic [63:0] add_key;
    logic [63:0] sub;
    logic [63:0] perm;
    logic [79:0] key_rot;
    logic [79:0] key_next;

    // 4-bit PRESENT S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Round key is always the top 64 bits of the running key register
    assign add_key = state_q ^ key_q[79:16];

    // sBoxLayer: sixteen parallel nibble substitutions
    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign sub[4*n +: 4] = sbox(add_key[4*n +: 4]);
    end

    // pLayer: bit j lands at 16*j mod 63, bit 63 is fixed
    for (genvar j = 0; j < 63; j++) begin : g_perm
        assign perm[(16*j) % 63] = sub[j];
    end
    assign perm[63] = sub[63];

    // Key schedule: rotate left 61, substitute top nibble, fold in round counter
    assign key_rot  = {key_q[18:0], key_q[79:19]};
    assign key_next = {sbox(key_rot[79:76]), key_rot[75:20],
                       key_rot[19:15] ^ rnd_q, key_rot[14:0]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state logic; start only matters in IDLE
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_d = ROUND;
            ROUND:   if (rnd_q == LAST_RND) fsm_d = FINAL;
            FINAL:   fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // FSM outputs, all decoded from registered state
    always_comb begin
        busy = (fsm_q != IDLE);
        done = done_q;
        dout = dout_q;
    end

    // Datapath next-state: load, iterate rounds, whiten into dout
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = din;
                    key_d   = key_in;
                    rnd_d   = 5'd1;
                end
            end
            ROUND: begin
                state_d = perm;
                key_d   = key_next;
                if (rnd_q != LAST_RND) begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            FINAL: begin
                dout_d = add_key;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset also clears dout so an aborted block leaves nothing behind
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 64'd0;
            key_q   <= 80'd0;
            rnd_q   <= 5'd0;
            dout_q  <= 64'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

endmodule
